dec_scan_unit: RTL

//   Registered, parametrised N-to-2^N one-hot decoder with active-high enable.
//   Two modes:
//   - DIRECT: decodes the sel input.
//   - SCAN: auto-rotates the one-hot output at a programmable rate.

---
 rtl/dec_scan_pkg.sv | 33 +++
 rtl/dec_scan_unit_if.sv | 37 +++
 rtl/dec_scan_prescaler.sv | 48 ++++
 rtl/dec_scan_unit.sv | 87 ++++++++
 4 files changed

// File: rtl/dec_scan_pkg.sv
// Shared types and helpers for the dec_scan_unit slice.
// Contents:
//   mode_e    - external mode selection (DIRECT / SCAN)
//   state_e   - FSM state encoding of the top level
//   onehot()  - decode an index into a one-hot vector of the widest legal size;
//               callers truncate the result to their own output width.
// Configuration macro affecting this slice: DEC_SCAN_ACTIVE_LOW_EN (used in the top).
package dec_scan_pkg;

   // Largest supported select width; the output width follows as 2**SEL_W.
   localparam int SEL_W_MAX = 5;
   localparam int OUT_W_MAX = 2 ** SEL_W_MAX;

   typedef enum logic {
      MODE_DIRECT = 1'b0,
      MODE_SCAN   = 1'b1
   } mode_e;

   typedef enum logic {
      ST_DIRECT = 1'b0,
      ST_SCAN   = 1'b1
   } state_e;

   // Returns a vector with only bit 'sel' set. Sized for the widest build so
   // that any instance can slice off the low OUT_W bits.
   function automatic logic [OUT_W_MAX-1:0] onehot(input logic [SEL_W_MAX-1:0] sel);
      logic [OUT_W_MAX-1:0] v;
      v      = '0;
      v[sel] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/dec_scan_unit_if.sv
// Bus interface of dec_scan_unit.
// Signals:
//   en       enable of the decoded outputs
//   mode     0 = DIRECT, 1 = SCAN
//   sel      index decoded in DIRECT mode
//   div_max  SCAN step period in cycles, minus 1
//   y        one-hot decoded output
//   idx      index currently driven on y
//   tick     one-cycle pulse on each SCAN step
// Modports:
//   master - the controller side (drives en/mode/sel/div_max)
//   slave  - the decoder side (drives y/idx/tick)
interface dec_scan_unit_if #(
   parameter int SEL_W = 2,
   parameter int DIV_W = 16
);
   localparam int OUT_W = 2 ** SEL_W;

   logic             en;
   logic             mode;
   logic [SEL_W-1:0] sel;
   logic [DIV_W-1:0] div_max;
   logic [OUT_W-1:0] y;
   logic [SEL_W-1:0] idx;
   logic             tick;

   modport master (
      output en, mode, sel, div_max,
      input  y, idx, tick
   );

   modport slave (
      input  en, mode, sel, div_max,
      output y, idx, tick
   );

endinterface

// File: rtl/dec_scan_prescaler.sv
// Step-rate prescaler for the SCAN mode of dec_scan_unit.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   clear    forces the counter to 0 and suppresses tick (DIRECT mode / scan entry)
//   hold     freezes the counter and suppresses tick (outputs disabled)
//   div_max  step period minus 1
//   wrap     combinational: a step happens on the coming edge
//   tick     registered one-cycle pulse marking each step
module dec_scan_prescaler #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             hold,
   input  logic [DIV_W-1:0] div_max,
   output logic             wrap,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;

   // Using >= rather than == means that lowering div_max below the current
   // count wraps on the next edge instead of running all the way round.
   assign wrap = !clear && !hold && (cnt >= div_max);

   // Counter and tick register. clear wins over hold so that entering SCAN
   // always starts a fresh period even when the outputs are disabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (clear) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (hold) begin
         tick <= 1'b0;
      end else if (wrap) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt + DIV_W'(1);
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/dec_scan_unit.sv
// Registered N-to-2^N one-hot decoder with a DIRECT mode (decode sel) and a
// SCAN mode (rotate the active line at a programmable rate), used to drive
// digit-select / row-strobe lines.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   dec_scan_unit_if.slave (en, mode, sel, div_max in; y, idx, tick out)
// Parameters: SEL_W (1..5, output width 2**SEL_W), DIV_W (prescaler width).
// Macro DEC_SCAN_ACTIVE_LOW_EN: when defined, y is bitwise inverted
// (idle/disabled value all ones, selected line 0); idx and tick are unchanged.
module dec_scan_unit
   import dec_scan_pkg::*;
#(
   parameter int SEL_W = 2,
   parameter int DIV_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   dec_scan_unit_if.slave    bus
);

   localparam int OUT_W = 2 ** SEL_W;

   state_e           state;
   mode_e            mode_in;
   logic [SEL_W-1:0] idx_q;
   logic [SEL_W-1:0] idx_next;
   logic [OUT_W-1:0] y_q;
   logic             clear;
   logic             hold;
   logic             wrap;
   logic             tick_q;

   assign mode_in = mode_e'(bus.mode);

   // The counter restarts whenever we are in, or just leaving, DIRECT mode,
   // so the first step after entering SCAN comes a full period later.
   assign clear = (mode_in == MODE_DIRECT) || (state == ST_DIRECT);
   assign hold  = !bus.en;

   dec_scan_prescaler #(
      .DIV_W (DIV_W)
   ) u_prescaler (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .hold    (hold),
      .div_max (bus.div_max),
      .wrap    (wrap),
      .tick    (tick_q)
   );

   // Next index: DIRECT follows sel, SCAN advances on each prescaler step and
   // otherwise keeps the last value (which is how a scan resumes from the
   // last decoded index). Natural SEL_W overflow gives the wrap to 0.
   always_comb begin
      idx_next = idx_q;
      if (mode_in == MODE_DIRECT) begin
         idx_next = bus.sel;
      end else if (wrap) begin
         idx_next = idx_q + SEL_W'(1);
      end
   end

   // FSM plus output registers. Mode is applied first (it decides idx_next),
   // then en only gates y, so y and idx always move on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_DIRECT;
         idx_q <= '0;
         y_q   <= '0;
      end else begin
         state <= (mode_in == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
         idx_q <= idx_next;
         y_q   <= bus.en ? OUT_W'(onehot(SEL_W_MAX'(idx_next))) : '0;
      end
   end

`ifdef DEC_SCAN_ACTIVE_LOW_EN
   assign bus.y = ~y_q;
`else
   assign bus.y = y_q;
`endif
   assign bus.idx  = idx_q;
   assign bus.tick = tick_q;

endmodule
